// File: rtl/demosaic_window_ctrl_if.sv
// rtl/demosaic_window_ctrl_if.sv - pixel-side handshake and window-side outputs of demosaic_window_ctrl
//
// Purpose: bundles the raw-pixel input qualifiers and every window-control output
//          so the controller and its neighbours connect through one port.
// Signals:
//   FRAME_START  pulse with pixel (0,0) of a frame, qualified by PIX_VALID
//   PIX_VALID    one raw Bayer pixel presented this cycle
//   LB_WR_EN     shift enable for the 4-line shift-RAM chain
//   WIN_EN       5x5 window valid
//   OUT_ROW      window centre row (11 bits)
//   OUT_COL      window centre column (11 bits)
//   UP_SEL       top-border mirror code (0 none, 1 one line, 2 two lines)
//   DN_SEL       bottom-border mirror code, same encoding
//   BUSY         controller not idle
//   FRAME_DONE   one-cycle pulse after the last window of a frame
//   OVERRUN      sticky protocol-error flag
// Modports: master drives the pixel qualifiers, slave is the controller.

interface demosaic_window_ctrl_if;
  logic        FRAME_START;
  logic        PIX_VALID;
  logic        LB_WR_EN;
  logic        WIN_EN;
  logic [10:0] OUT_ROW;
  logic [10:0] OUT_COL;
  logic [1:0]  UP_SEL;
  logic [1:0]  DN_SEL;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        OVERRUN;

  modport master (
    output FRAME_START,
    output PIX_VALID,
    input  LB_WR_EN,
    input  WIN_EN,
    input  OUT_ROW,
    input  OUT_COL,
    input  UP_SEL,
    input  DN_SEL,
    input  BUSY,
    input  FRAME_DONE,
    input  OVERRUN
  );

  modport slave (
    input  FRAME_START,
    input  PIX_VALID,
    output LB_WR_EN,
    output WIN_EN,
    output OUT_ROW,
    output OUT_COL,
    output UP_SEL,
    output DN_SEL,
    output BUSY,
    output FRAME_DONE,
    output OVERRUN
  );
endinterface

// File: rtl/demosaic_window_ctrl.sv
// rtl/demosaic_window_ctrl.sv - 5x5 demosaic window sequencer for a 4-line shift-RAM chain
//
// Purpose: counts incoming raw pixels, enables the line-buffer shift, and
//          produces one window-centre coordinate per accepted pixel once two
//          lines are buffered, then flushes the last two centre rows with
//          dummy shifts after the final pixel of the frame.
// Parameters:
//   COLS  pixels per line (>= 4)
//   ROWS  lines per frame (>= 5)
// Ports:
//   INCLK  pixel clock, rising edge
//   RST    asynchronous active-high reset
//   bus    demosaic_window_ctrl_if.slave (pixel qualifiers in, window control out)

module demosaic_window_ctrl #(
  parameter int COLS = 562,
  parameter int ROWS = 788
) (
  input  logic                   INCLK,
  input  logic                   RST,
  demosaic_window_ctrl_if.slave  bus
);

  localparam logic [10:0] COL_LAST  = 11'(COLS - 1);
  localparam logic [10:0] ROW_LAST  = 11'(ROWS - 1);
  localparam logic [10:0] ROW_FLUSH = 11'(ROWS - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q;
  // In FILL/RUN these hold the coordinate of the next pixel to arrive;
  // in FLUSH they are reused as the centre of the next flush window.
  logic [10:0] in_row_q;
  logic [10:0] in_col_q;

  logic        win_en_q;
  logic [10:0] out_row_q;
  logic [10:0] out_col_q;
  logic [1:0]  up_sel_q;
  logic [1:0]  dn_sel_q;
  logic        frame_done_q;
  logic        done_pend_q;
  logic        overrun_q;

  logic        start;
  logic        accept;
  logic        col_last;
  logic [10:0] col_nxt;
  logic [10:0] row_nxt;
  logic [10:0] win_row_d;
  logic [10:0] win_col_d;
  logic [1:0]  up_sel_d;
  logic [1:0]  dn_sel_d;

  // A frame start restarts the frame from any state.
  assign start  = bus.PIX_VALID & bus.FRAME_START;
  assign accept = start | (bus.PIX_VALID & ((state_q == FILL) | (state_q == RUN)));

  // Gate with RST so the combinational enable is also low during reset,
  // even while the pixel source keeps presenting a frame start.
  assign bus.LB_WR_EN = ~RST & (accept | (state_q == FLUSH));
  assign bus.BUSY     = (state_q != IDLE);

  assign col_last = (in_col_q == COL_LAST);
  assign col_nxt  = col_last ? 11'd0 : in_col_q + 11'd1;
  assign row_nxt  = col_last ? ((in_row_q == ROW_LAST) ? 11'd0 : in_row_q + 11'd1)
                             : in_row_q;

  // The window centre lags the incoming pixel by two lines; during FLUSH the
  // counters already hold the centre directly.
  always_comb begin
    win_row_d = (state_q == FLUSH) ? in_row_q : in_row_q - 11'd2;
    win_col_d = in_col_q;
    up_sel_d  = 2'd0;
    dn_sel_d  = 2'd0;
    if (win_row_d == 11'd0) begin
      up_sel_d = 2'd2;
    end else if (win_row_d == 11'd1) begin
      up_sel_d = 2'd1;
    end
    if (win_row_d == ROW_LAST) begin
      dn_sel_d = 2'd2;
    end else if (win_row_d == ROW_FLUSH) begin
      dn_sel_d = 2'd1;
    end
  end

  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      in_row_q     <= 11'd0;
      in_col_q     <= 11'd0;
      win_en_q     <= 1'b0;
      out_row_q    <= 11'd0;
      out_col_q    <= 11'd0;
      up_sel_q     <= 2'd0;
      dn_sel_q     <= 2'd0;
      frame_done_q <= 1'b0;
      done_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      win_en_q     <= 1'b0;
      // FRAME_DONE trails the final window by one cycle.
      frame_done_q <= done_pend_q;
      done_pend_q  <= 1'b0;

      if (start) begin
        // The start pixel itself is (0,0); a start outside IDLE aborts the
        // frame in progress and drops whatever windows it still owed.
        if (state_q != IDLE) begin
          overrun_q <= 1'b1;
        end
        state_q  <= FILL;
        in_row_q <= 11'd0;
        in_col_q <= 11'd1;
      end else begin
        case (state_q)
          IDLE: begin
            // Stray pixels before a frame start are silently ignored.
          end

          FILL: begin
            if (bus.PIX_VALID) begin
              in_row_q <= row_nxt;
              in_col_q <= col_nxt;
              // Pixel (2,0) completes the two look-ahead lines, so it
              // already yields the first window (centre (0,0)).
              if (in_row_q == 11'd2) begin
                state_q   <= RUN;
                win_en_q  <= 1'b1;
                out_row_q <= win_row_d;
                out_col_q <= win_col_d;
                up_sel_q  <= up_sel_d;
                dn_sel_q  <= dn_sel_d;
              end
            end
          end

          RUN: begin
            if (bus.PIX_VALID) begin
              win_en_q  <= 1'b1;
              out_row_q <= win_row_d;
              out_col_q <= win_col_d;
              up_sel_q  <= up_sel_d;
              dn_sel_q  <= dn_sel_d;
              if ((in_row_q == ROW_LAST) && col_last) begin
                state_q  <= FLUSH;
                in_row_q <= ROW_FLUSH;
                in_col_q <= 11'd0;
              end else begin
                in_row_q <= row_nxt;
                in_col_q <= col_nxt;
              end
            end
          end

          FLUSH: begin
            // No input is expected while the last two rows drain.
            if (bus.PIX_VALID) begin
              overrun_q <= 1'b1;
            end
            win_en_q  <= 1'b1;
            out_row_q <= win_row_d;
            out_col_q <= win_col_d;
            up_sel_q  <= up_sel_d;
            dn_sel_q  <= dn_sel_d;
            if ((in_row_q == ROW_LAST) && col_last) begin
              state_q     <= IDLE;
              in_row_q    <= 11'd0;
              in_col_q    <= 11'd0;
              done_pend_q <= 1'b1;
            end else begin
              in_row_q <= row_nxt;
              in_col_q <= col_nxt;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.WIN_EN     = win_en_q;
  assign bus.OUT_ROW    = out_row_q;
  assign bus.OUT_COL    = out_col_q;
  assign bus.UP_SEL     = up_sel_q;
  assign bus.DN_SEL     = dn_sel_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.OVERRUN    = overrun_q;

endmodule
